// File: rtl/hd44780_pkg.sv
// Shared constants for the hd44780 refresh controller: FSM encoding, fill character
// and the 4x16 character line layout of the frame buffer.
package hd44780_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_CLEAR      = 3'd0;
  localparam state_t ST_IDLE       = 3'd1;
  localparam state_t ST_HOLDOFF    = 3'd2;
  localparam state_t ST_TRIGGER    = 3'd3;
  localparam state_t ST_WAIT_START = 3'd4;
  localparam state_t ST_WAIT_DONE  = 3'd5;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  localparam int unsigned LINE_WIDTH = 16;
  localparam logic [5:0]  LINE0_BASE = 6'h00;
  localparam logic [5:0]  LINE1_BASE = 6'h10;
  localparam logic [5:0]  LINE2_BASE = 6'h20;
  localparam logic [5:0]  LINE3_BASE = 6'h30;

endpackage

// File: rtl/hd44780_fb_ram.sv
// Character frame buffer: one synchronous write port, one asynchronous read port.
module hd44780_fb_ram #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hd44780_refresh_ctrl.sv
// Frame-buffer owner for the hd44780 driver: arbitrates two writers and pulses lcd_trg
// when content is dirty, the driver is idle and the minimum refresh gap has elapsed.
module hd44780_refresh_ctrl
  import hd44780_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 6,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       MIN_GAP     = 2500,
  parameter int unsigned       ACK_TIMEOUT = 16,
  parameter logic [DATA_W-1:0] FILL_CHAR   = DATA_W'(hd44780_pkg::FILL_CHAR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              force_refresh,
  input  logic              lcd_busy,
  output logic              lcd_trg,
  input  logic [ADDR_W-1:0] lcd_addr,
  output logic [DATA_W-1:0] lcd_data,
  output logic              refresh_active,
  output logic              dirty,
  output logic [15:0]       refresh_count
);

  localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              dirty_q, dirty_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              in_clear;
  logic              wr_acc;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_data;

  assign in_clear   = (state_q == ST_CLEAR);
  assign req0_ready = !in_clear && req0_valid && (!req1_valid || !rr_q);
  assign req1_ready = !in_clear && req1_valid && (!req0_valid || rr_q);
  assign wr_acc     = req0_ready || req1_ready;

  always_comb begin
    we    = 1'b0;
    waddr = req0_addr;
    wdata = req0_data;
    if (in_clear) begin
      we    = 1'b1;
      waddr = clr_ptr_q;
      wdata = FILL_CHAR;
    end else if (req1_ready) begin
      we    = 1'b1;
      waddr = req1_addr;
      wdata = req1_data;
    end else if (req0_ready) begin
      we    = 1'b1;
    end
  end

  hd44780_fb_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fb_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (lcd_addr),
    .rdata_o (rd_data)
  );

  // Forward the write in flight so the driver sees it in the cycle it is accepted.
  assign lcd_data = (we && (waddr == lcd_addr)) ? wdata : rd_data;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    dirty_d   = dirty_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    gap_d     = (gap_q < GAP_MAX) ? gap_q + 1'b1 : gap_q;
    rr_d      = req0_ready ? 1'b1 : (req1_ready ? 1'b0 : rr_q);

    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!lcd_busy && dirty_q) begin
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if ((gap_q == GAP_MAX) && !lcd_busy) begin
          state_d = ST_TRIGGER;
        end
      end
      ST_TRIGGER: begin
        dirty_d = 1'b0;
        tmr_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // The driver gets ACK_TIMEOUT cycles to acknowledge before a retry is scheduled.
        if (lcd_busy) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          dirty_d = 1'b1;
          gap_d   = '0;
          state_d = ST_HOLDOFF;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          gap_d   = '0;
          state_d = dirty_q ? ST_HOLDOFF : ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    // New content or an explicit request always wins over the clear in TRIGGER.
    if (wr_acc || force_refresh) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      dirty_q   <= 1'b1;
      cnt_q     <= 16'd0;
      rr_q      <= 1'b0;
      gap_q     <= GAP_MAX;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      dirty_q   <= dirty_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      tmr_q     <= tmr_d;
    end
  end

  assign lcd_trg        = (state_q == ST_TRIGGER);
  assign refresh_active = (state_q == ST_TRIGGER) || (state_q == ST_WAIT_START) ||
                          (state_q == ST_WAIT_DONE);
  assign dirty          = dirty_q;
  assign refresh_count  = cnt_q;

endmodule

// File: tb/tb_hd44780_refresh_ctrl.sv
// Scoreboard bench for hd44780_refresh_ctrl: grants and trigger pulses are checked by a
// monitor against queued expectations; a small driver model answers lcd_trg with busy.
module tb_hd44780_refresh_ctrl;

  localparam int unsigned MIN_GAP     = 2500;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [5:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       force_refresh = 1'b0;
  logic       lcd_busy, lcd_trg;
  logic [5:0] lcd_addr = '0;
  logic [7:0] lcd_data;
  logic       refresh_active, dirty;
  logic [15:0] refresh_count;

  logic init_busy  = 1'b1;
  logic model_busy = 1'b0;
  bit   drv_en     = 1'b1;
  int   drv_len    = 20;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int trg_cyc = 0;
  int trg_events = 0;
  int hs0 = 0;
  int hs1 = 0;
  int grant_exp[$];
  int trg_exp[$];

  assign lcd_busy = init_busy | model_busy;

  always #5 clk = ~clk;

  hd44780_refresh_ctrl #(
    .MIN_GAP     (MIN_GAP),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .force_refresh  (force_refresh),
    .lcd_busy       (lcd_busy),
    .lcd_trg        (lcd_trg),
    .lcd_addr       (lcd_addr),
    .lcd_data       (lcd_data),
    .refresh_active (refresh_active),
    .dirty          (dirty),
    .refresh_count  (refresh_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trg(input int n, input int budget, input string name);
    int k = 0;
    while (trg_events < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, trg_events, n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((refresh_active || dirty) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, {refresh_active, dirty}, 0);
  endtask

  task automatic pulse_force();
    force_refresh = 1'b1;
    tick(1);
    force_refresh = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Driver model: busy rises the cycle after trg, holds drv_len cycles, then falls.
  initial begin
    forever begin
      @(negedge clk);
      if (lcd_trg && drv_en) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (drv_len) @(posedge clk);
        #1 model_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT grants a write or pulses lcd_trg.
  initial begin
    logic trg_prev = 1'b0;
    int   exp;
    forever begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin
        hs0++;
        exp = (grant_exp.size() > 0) ? grant_exp.pop_front() : -1;
        check("grant_id", 0, exp);
      end
      if (req1_valid && req1_ready) begin
        hs1++;
        exp = (grant_exp.size() > 0) ? grant_exp.pop_front() : -1;
        check("grant_id", 1, exp);
      end
      if (lcd_trg && !trg_prev) begin
        trg_cyc = cyc;
        trg_events++;
        exp = (trg_exp.size() > 0) ? trg_exp.pop_front() : 32'hDEAD;
        check("trg_count", {16'd0, refresh_count}, exp);
        check("trg_while_busy", lcd_busy, 0);
      end
      trg_prev = lcd_trg;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy_hi;
    int bad;
    int first;

    // Reset and CLEAR: writers held off for 64 cycles, then every cell holds 8'h20.
    tick(3);
    rst = 1'b0;
    check("rst_trg", lcd_trg, 0);
    check("rst_active", refresh_active, 0);
    check("rst_dirty", dirty, 1);
    check("rst_count", refresh_count, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rdy_hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (req0_ready || req1_ready) rdy_hi++;
      if (i == 63) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick(1);
    end
    check("clear_ready", rdy_hi, 0);
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      lcd_addr = 6'(a);
      #1;
      if (lcd_data !== 8'h20) bad++;
    end
    check("clear_fill", bad, 0);
    check("init_wait_dirty", dirty, 1);

    // Round-robin: both writers for 4 cycles, grants 0,1,0,1.
    grant_exp.push_back(0);
    grant_exp.push_back(1);
    grant_exp.push_back(0);
    grant_exp.push_back(1);
    req0_addr = 6'h10; req0_data = 8'h61;
    req1_addr = 6'h11; req1_data = 8'h62;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(1);
    check("hs0", hs0, 2);
    check("hs1", hs1, 2);
    lcd_addr = 6'h10; #1;
    check("rr_data0", lcd_data, 8'h61);
    lcd_addr = 6'h11; #1;
    check("rr_data1", lcd_data, 8'h62);
    check("no_trg_init_busy", trg_events, 0);

    // 'A' at 0x05, then driver init finishes: exactly one refresh.
    grant_exp.push_back(0);
    req0_addr = 6'h05; req0_data = 8'h41;
    req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0;
    lcd_addr = 6'h05; #1;
    check("wr_A", lcd_data, 8'h41);
    trg_exp.push_back(0);
    init_busy = 1'b0;
    wait_trg(1, 100, "first_trg");
    wait_idle(1000, "first_idle");
    tick(20);
    check("one_trg", trg_events, 1);
    check("count_1", refresh_count, 1);
    check("dirty_0", dirty, 0);

    // Write torn into WAIT_DONE forces a follow-up refresh MIN_GAP+1 edges after busy falls.
    drv_len = 200;
    trg_exp.push_back(1);
    pulse_force();
    wait_trg(2, MIN_GAP + 100, "force_trg");
    tick(10);
    grant_exp.push_back(1);
    req1_addr = 6'h20; req1_data = 8'h5A;
    req1_valid = 1'b1;
    tick(1);
    req1_valid = 1'b0;
    check("tear_dirty", dirty, 1);
    trg_exp.push_back(2);
    wait_trg(3, MIN_GAP + 400, "tear_trg");
    check("gap_after_busy", trg_cyc - (fall_cyc + 1), MIN_GAP + 1);
    wait_idle(1000, "tear_idle");
    check("count_3", refresh_count, 3);

    // No ack: trg, ACK_TIMEOUT cycles waiting, MIN_GAP+1 holdoff, retry trg.
    drv_len = 20;
    drv_en = 1'b0;
    trg_exp.push_back(3);
    trg_exp.push_back(3);
    pulse_force();
    wait_trg(4, MIN_GAP + 100, "noack_trg");
    first = trg_cyc;
    drv_en = 1'b1;
    tick(ACK_TIMEOUT + 3);
    check("timeout_dirty", dirty, 1);
    check("timeout_inactive", refresh_active, 0);
    wait_trg(5, MIN_GAP + ACK_TIMEOUT + 50, "retry_trg");
    check("retry_interval", trg_cyc - first, MIN_GAP + ACK_TIMEOUT + 2);
    wait_idle(1000, "retry_idle");
    check("count_4", refresh_count, 4);

    // Reset in WAIT_DONE aborts the refresh and reruns CLEAR.
    drv_len = 200;
    trg_exp.push_back(4);
    pulse_force();
    wait_trg(6, MIN_GAP + 100, "pre_rst_trg");
    tick(10);
    init_busy = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst2_trg", lcd_trg, 0);
    check("rst2_active", refresh_active, 0);
    check("rst2_dirty", dirty, 1);
    check("rst2_count", refresh_count, 0);
    req0_valid = 1'b1;
    #1;
    check("rst2_ready", req0_ready, 0);
    req0_valid = 1'b0;
    tick(64);
    bad = 0;
    lcd_addr = 6'h05; #1;
    if (lcd_data !== 8'h20) bad++;
    lcd_addr = 6'h10; #1;
    if (lcd_data !== 8'h20) bad++;
    lcd_addr = 6'h20; #1;
    if (lcd_data !== 8'h20) bad++;
    check("rst2_refill", bad, 0);
    tick(300);
    check("rst2_no_trg", trg_events, 6);
    check("sb_empty", grant_exp.size() + trg_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
